hazard_scoreboard: RTL and testbench

Pipeline hazard controller for the RISC-V core, sitting beside the ID stage. It tracks pending register writes from the long-latency units (iterative divider, multi-cycle FPU) in a 64-entry scoreboard covering 32 integer and 32 float registers. It also detects load-use hazards against the EX stage. From these it generates stall and bubble control, and the start strobes for the long-latency units.

---
 rtl/riscv_hz_pkg.sv | 17 +
 rtl/lu_tracker.sv | 89 ++++++++
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hz_pkg.sv
// Shared encodings for the ID-stage hazard controller: instruction classes,
// default divider latency and the long-latency tracker state.
package riscv_hz_pkg;

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_LOAD   = 2'b01;
    localparam logic [1:0] CLS_DIV    = 2'b10;
    localparam logic [1:0] CLS_FPU    = 2'b11;

    localparam int DIV_LAT_DEFAULT = 34;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } trk_state_t;

endpackage

// File: rtl/lu_tracker.sv
// Occupancy tracker for one long-latency unit. Captures the destination of the
// issued op and emits a one-cycle clear when the result lands, either after a
// fixed latency (internal counter) or on an external completion pulse.
module lu_tracker
    import riscv_hz_pkg::*;
#(
    parameter bit FIXED_LAT = 1'b0,
    parameter int LAT       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] start_rd,
    input  logic       start_float,
    input  logic       start_wb,
    input  logic       done,
    output logic       busy,
    output logic       clr,
    output logic [4:0] clr_rd,
    output logic       clr_float,
    output logic       state_dbg
);

    localparam logic [7:0] LAT8 = 8'(LAT);

    trk_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [4:0] rd_q;
    logic       flt_q;
    logic       wb_q;
    logic       finish;

    // State, latency counter and captured destination registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            rd_q  <= 5'd0;
            flt_q <= 1'b0;
            wb_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start && state == IDLE) begin
                rd_q  <= start_rd;
                flt_q <= start_float;
                wb_q  <= start_wb;
            end
        end
    end

    // Next-state logic; finish marks the last busy cycle of the op.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = FIXED_LAT ? LAT8 : 8'd0;
                end
            end
            BUSY: begin
                if (FIXED_LAT) begin
                    if (cnt == 8'd1) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end else if (done) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An op issued without a writeback owns no scoreboard bit, so it clears nothing.
    assign busy      = (state == BUSY);
    assign clr       = finish & wb_q;
    assign clr_rd    = rd_q;
    assign clr_float = flt_q;
    assign state_dbg = (state == BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard controller: 64-bit register scoreboard for long-latency
// writes, RAW/WAW/load-use/structural detection, stall/bubble generation and
// issue strobes for the divider and the multi-cycle FPU.
module hazard_scoreboard
    import riscv_hz_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       id_valid,
    input  logic [1:0] id_class,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [1:0] id_float_read,
    input  logic [4:0] id_rd,
    input  logic       id_rd_float,
    input  logic       id_wb,
    input  logic       ex_memr,
    input  logic       ex_wb,
    input  logic [4:0] ex_rd,
    input  logic       ex_rd_float,
    input  logic       fpu_done,
    output logic       stall,
    output logic       bubble,
    output logic       div_start,
    output logic       fpu_start,
    output logic       div_busy,
    output logic       fpu_busy
);

    logic [31:0] sb_int, sb_fp;
    logic [31:0] set_int, set_fp, clr_int, clr_fp;
    logic        pend_rs1, pend_rs2, pend_rd;
    logic        lu_rs1, lu_rs2, structural, hazard, issue_ok;
    logic        div_clr, fpu_clr, div_clr_float, fpu_clr_float;
    logic [4:0]  div_clr_rd, fpu_clr_rd;
    logic        div_state, fpu_state;

    // Hazard detection; only the registered scoreboard is consulted, so a bit
    // clearing this cycle still blocks until the next one.
    always_comb begin
        pend_rs1   = id_float_read[1] ? sb_fp[id_rs1] : sb_int[id_rs1];
        pend_rs2   = id_float_read[0] ? sb_fp[id_rs2] : sb_int[id_rs2];
        pend_rd    = id_wb & (id_rd_float ? sb_fp[id_rd] : sb_int[id_rd]);
        lu_rs1     = ex_memr & ex_wb & (ex_rd_float == id_float_read[1]) &
                     (ex_rd == id_rs1) & (id_float_read[1] | (ex_rd != 5'd0));
        lu_rs2     = ex_memr & ex_wb & (ex_rd_float == id_float_read[0]) &
                     (ex_rd == id_rs2) & (id_float_read[0] | (ex_rd != 5'd0));
        structural = ((id_class == CLS_DIV) & div_busy) |
                     ((id_class == CLS_FPU) & fpu_busy);
        hazard     = pend_rs1 | pend_rs2 | pend_rd | lu_rs1 | lu_rs2 | structural;
        stall      = id_valid & ~flush & hazard;
        bubble     = stall | flush;
        issue_ok   = id_valid & ~flush & ~stall;
        div_start  = issue_ok & (id_class == CLS_DIV);
        fpu_start  = issue_ok & (id_class == CLS_FPU);
    end

    // Scoreboard set/clear masks; integer x0 is never marked pending.
    always_comb begin
        set_int = 32'd0;
        set_fp  = 32'd0;
        clr_int = 32'd0;
        clr_fp  = 32'd0;
        if ((div_start | fpu_start) & id_wb) begin
            if (id_rd_float)
                set_fp[id_rd] = 1'b1;
            else if (id_rd != 5'd0)
                set_int[id_rd] = 1'b1;
        end
        if (div_clr) begin
            if (div_clr_float) clr_fp[div_clr_rd] = 1'b1;
            else               clr_int[div_clr_rd] = 1'b1;
        end
        if (fpu_clr) begin
            if (fpu_clr_float) clr_fp[fpu_clr_rd] = 1'b1;
            else               clr_int[fpu_clr_rd] = 1'b1;
        end
    end

    // Scoreboard register; a set in the same cycle as a clear of that bit wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_int <= 32'd0;
            sb_fp  <= 32'd0;
        end else begin
            sb_int <= (sb_int & ~clr_int) | set_int;
            sb_fp  <= (sb_fp & ~clr_fp) | set_fp;
        end
    end

    lu_tracker #(
        .FIXED_LAT (1'b1),
        .LAT       (DIV_LAT)
    ) u_div_trk (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .start_rd    (id_rd),
        .start_float (id_rd_float),
        .start_wb    (id_wb),
        .done        (1'b0),
        .busy        (div_busy),
        .clr         (div_clr),
        .clr_rd      (div_clr_rd),
        .clr_float   (div_clr_float),
        .state_dbg   (div_state)
    );

    lu_tracker #(
        .FIXED_LAT (1'b0),
        .LAT       (2)
    ) u_fpu_trk (
        .clk         (clk),
        .rst         (rst),
        .start       (fpu_start),
        .start_rd    (id_rd),
        .start_float (id_rd_float),
        .start_wb    (id_wb),
        .done        (fpu_done),
        .busy        (fpu_busy),
        .clr         (fpu_clr),
        .clr_rd      (fpu_clr_rd),
        .clr_float   (fpu_clr_float),
        .state_dbg   (fpu_state)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard. The driver applies one cycle of inputs and
// queues the expected outputs {stall,bubble,div_start,fpu_start,div_busy,fpu_busy},
// optionally with one scoreboard bit to probe; the monitor pops and compares
// on every falling edge.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       id_valid;
    logic [1:0] id_class;
    logic [4:0] id_rs1, id_rs2;
    logic [1:0] id_float_read;
    logic [4:0] id_rd;
    logic       id_rd_float;
    logic       id_wb;
    logic       ex_memr, ex_wb;
    logic [4:0] ex_rd;
    logic       ex_rd_float;
    logic       fpu_done;
    logic       stall, bubble, div_start, fpu_start, div_busy, fpu_busy;

    // entry layout: {probe_en, probe_fp, probe_idx[4:0], probe_val, outputs[5:0]}
    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    hazard_scoreboard #(.DIV_LAT(34)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_class      (id_class),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_float_read (id_float_read),
        .id_rd         (id_rd),
        .id_rd_float   (id_rd_float),
        .id_wb         (id_wb),
        .ex_memr       (ex_memr),
        .ex_wb         (ex_wb),
        .ex_rd         (ex_rd),
        .ex_rd_float   (ex_rd_float),
        .fpu_done      (fpu_done),
        .stall         (stall),
        .bubble        (bubble),
        .div_start     (div_start),
        .fpu_start     (fpu_start),
        .div_busy      (div_busy),
        .fpu_busy      (fpu_busy)
    );

    // clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // monitor: compare outputs (and optional scoreboard probe) every cycle
    logic [13:0] mon_e;
    string       mon_t;
    logic [5:0]  mon_got;
    logic        mon_bit;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e   = exp_q.pop_front();
            mon_t   = tag_q.pop_front();
            mon_got = {stall, bubble, div_start, fpu_start, div_busy, fpu_busy};
            n_checks++;
            if (mon_got !== mon_e[5:0]) begin
                n_fail++;
                $display("FAIL %s: outputs got %b required %b (stall,bubble,div_start,fpu_start,div_busy,fpu_busy)",
                         mon_t, mon_got, mon_e[5:0]);
            end
            if (mon_e[13]) begin
                mon_bit = mon_e[12] ? dut.sb_fp[mon_e[11:7]] : dut.sb_int[mon_e[11:7]];
                n_checks++;
                if (mon_bit !== mon_e[6]) begin
                    n_fail++;
                    $display("FAIL %s: sb_%s[%0d] got %b required %b", mon_t,
                             mon_e[12] ? "fp" : "int", mon_e[11:7], mon_bit, mon_e[6]);
                end
            end
        end
    end

    // driver tasks
    task automatic step(input logic [5:0] vec, input string tag);
        exp_q.push_back({1'b0, 1'b0, 5'd0, 1'b0, vec});
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic step_sb(input logic [5:0] vec, input logic fp, input logic [4:0] idx,
                           input logic val, input string tag);
        exp_q.push_back({1'b1, fp, idx, val, vec});
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic set_id(input logic [1:0] cls, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [1:0] fr, input logic [4:0] rd, input logic rdf,
                          input logic wb);
        id_valid      = 1'b1;
        id_class      = cls;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_float_read = fr;
        id_rd         = rd;
        id_rd_float   = rdf;
        id_wb         = wb;
    endtask

    task automatic clr_id();
        id_valid      = 1'b0;
        id_class      = 2'b00;
        id_rs1        = 5'd0;
        id_rs2        = 5'd0;
        id_float_read = 2'b00;
        id_rd         = 5'd0;
        id_rd_float   = 1'b0;
        id_wb         = 1'b0;
    endtask

    task automatic set_ex(input logic memr, input logic wb, input logic [4:0] rd, input logic rdf);
        ex_memr     = memr;
        ex_wb       = wb;
        ex_rd       = rd;
        ex_rd_float = rdf;
    endtask

    // stimulus
    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fpu_done = 1'b0;
        clr_id();
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step_sb(6'b000000, 1'b0, 5'd5, 1'b0, "reset_idle");
        step_sb(6'b000000, 1'b1, 5'd3, 1'b0, "reset_idle_fp");

        // divider RAW: div x5 then add x6,x5,x1
        set_id(2'b10, 5'd1, 5'd2, 2'b00, 5'd5, 1'b0, 1'b1);
        step(6'b001000, "div_issue");
        set_id(2'b00, 5'd5, 5'd1, 2'b00, 5'd6, 1'b0, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            if (k == 1 || k == 34) step_sb(6'b110010, 1'b0, 5'd5, 1'b1, "div_raw_stall");
            else                   step(6'b110010, "div_raw_stall");
        end
        step_sb(6'b000000, 1'b0, 5'd5, 1'b0, "div_raw_issue");
        clr_id();

        // load-use: integer, float-mismatch, x0, float
        set_id(2'b00, 5'd7, 5'd2, 2'b00, 5'd8, 1'b0, 1'b1);
        set_ex(1'b1, 1'b1, 5'd7, 1'b0);
        step(6'b110000, "load_use_int");
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        step(6'b000000, "load_use_released");
        set_ex(1'b1, 1'b1, 5'd7, 1'b1);
        step(6'b000000, "load_use_bank_mismatch");
        set_id(2'b00, 5'd0, 5'd2, 2'b00, 5'd8, 1'b0, 1'b1);
        set_ex(1'b1, 1'b1, 5'd0, 1'b0);
        step(6'b000000, "load_use_x0");
        set_id(2'b00, 5'd7, 5'd2, 2'b11, 5'd8, 1'b1, 1'b1);
        set_ex(1'b1, 1'b1, 5'd7, 1'b1);
        step(6'b110000, "load_use_fp");
        set_ex(1'b1, 1'b0, 5'd7, 1'b1);
        step(6'b000000, "load_use_no_wb");
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        clr_id();

        // FPU WAW and completion
        set_id(2'b11, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b1);
        step(6'b000100, "fpu_issue");
        set_id(2'b00, 5'd4, 5'd5, 2'b11, 5'd3, 1'b1, 1'b1);
        step_sb(6'b110001, 1'b1, 5'd3, 1'b1, "fpu_waw_stall");
        step(6'b110001, "fpu_waw_stall");
        step(6'b110001, "fpu_waw_stall");
        fpu_done = 1'b1;
        step(6'b110001, "fpu_done_cycle");
        fpu_done = 1'b0;
        step_sb(6'b000000, 1'b1, 5'd3, 1'b0, "fpu_waw_issue");
        clr_id();
        fpu_done = 1'b1;
        step(6'b000000, "fpu_stray_done");
        fpu_done = 1'b0;
        step_sb(6'b000000, 1'b1, 5'd3, 1'b0, "fpu_stray_after");

        // structural: second div while divider busy
        set_id(2'b10, 5'd1, 5'd2, 2'b00, 5'd10, 1'b0, 1'b1);
        step(6'b001000, "struct_div1");
        set_id(2'b10, 5'd1, 5'd2, 2'b00, 5'd11, 1'b0, 1'b1);
        for (int k = 1; k <= 34; k++) step(6'b110010, "struct_stall");
        step_sb(6'b001000, 1'b0, 5'd10, 1'b0, "struct_div2_start");
        clr_id();
        step_sb(6'b000010, 1'b0, 5'd11, 1'b1, "struct_div2_busy");
        for (int k = 2; k <= 34; k++) step(6'b000010, "struct_div2_busy");
        step_sb(6'b000000, 1'b0, 5'd11, 1'b0, "struct_div2_done");

        // flush priority over RAW and structural hazards
        set_id(2'b10, 5'd1, 5'd2, 2'b00, 5'd5, 1'b0, 1'b1);
        step(6'b001000, "flush_div_issue");
        flush = 1'b1;
        set_id(2'b00, 5'd5, 5'd1, 2'b00, 5'd6, 1'b0, 1'b1);
        step(6'b010010, "flush_raw");
        set_id(2'b10, 5'd5, 5'd1, 2'b00, 5'd12, 1'b0, 1'b1);
        step(6'b010010, "flush_div_in_id");
        flush = 1'b0;
        clr_id();
        for (int k = 3; k <= 34; k++) begin
            if (k == 34) step_sb(6'b000010, 1'b0, 5'd5, 1'b1, "flush_inflight");
            else         step(6'b000010, "flush_inflight");
        end
        step_sb(6'b000000, 1'b0, 5'd5, 1'b0, "flush_clear_on_time");
        step_sb(6'b000000, 1'b0, 5'd12, 1'b0, "flush_no_set");

        // reset in the middle of a divide
        set_id(2'b10, 5'd1, 5'd2, 2'b00, 5'd5, 1'b0, 1'b1);
        step(6'b001000, "rst_div_issue");
        clr_id();
        for (int k = 1; k <= 19; k++) begin
            if (k == 1) step_sb(6'b000010, 1'b0, 5'd5, 1'b1, "rst_div_busy");
            else        step(6'b000010, "rst_div_busy");
        end
        rst = 1'b1;
        step(6'b000010, "rst_asserted");
        rst = 1'b0;
        set_id(2'b00, 5'd5, 5'd1, 2'b00, 5'd6, 1'b0, 1'b1);
        step_sb(6'b000000, 1'b0, 5'd5, 1'b0, "rst_read_x5");
        set_id(2'b10, 5'd5, 5'd1, 2'b00, 5'd9, 1'b0, 1'b1);
        step(6'b001000, "rst_new_div");
        clr_id();
        for (int k = 1; k <= 34; k++) step(6'b000010, "rst_new_div_busy");
        step_sb(6'b000000, 1'b0, 5'd9, 1'b0, "rst_new_div_done");

        // let the monitor consume the last entry
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
